// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: default widths,
// reset vector and the fetch/decide state encoding.
package pc_sequencer_pkg;

    localparam int unsigned PC_W_DEF      = 16;
    localparam int unsigned RAS_DEPTH_DEF = 4;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_DECIDE = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest
// entry, while the occupancy count saturates at DEPTH.
module ras_stack #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_top,
    output logic          o_empty,
    output logic          o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_top_idx;

    assign w_top_idx = r_wptr - PTR_W'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_cnt == CNT_W'(0));
    assign o_full    = (r_cnt == CNT_W'(DEPTH));

    // The write pointer wraps, so a push on a full stack lands on the oldest slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_cnt  <= '0;
        end else if (i_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
            if (!o_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_wptr <= w_top_idx;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC: fetches over a req/ack handshake, then selects the next PC
// (ret > call > jump > branch > sequential) once decode releases the stall.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] sign_imm,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] pc_branch,
    output logic            ras_err
);

    seq_state_e      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_ras_err;

    logic            w_advance;
    logic            w_push;
    logic            w_pop;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic [PC_W-1:0] w_ras_top;
    logic [PC_W-1:0] w_next_pc;
    logic            w_err_evt;

    assign pc_plus1  = r_pc + PC_W'(1);
    assign pc_branch = sign_imm + pc_plus1;

    assign w_advance = (r_state == ST_DECIDE) && !stall;
    assign w_push    = w_advance && !ret && call;
    assign w_pop     = w_advance && ret && !w_ras_empty;
    assign w_err_evt = w_advance && ((ret && w_ras_empty) || (!ret && call && w_ras_full));

    ras_stack #(
        .DW    (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (pc_plus1),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full)
    );

    always_comb begin
        w_next_pc = pc_plus1;
        if (ret) begin
            w_next_pc = w_ras_empty ? pc_plus1 : w_ras_top;
        end else if (call || jump) begin
            w_next_pc = jump_target;
        end else if (branch_taken) begin
            w_next_pc = pc_branch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_ras_err <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (!stall) begin
                        r_state <= ST_FETCH;
                        r_pc    <= w_next_pc;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
            if (w_err_evt) begin
                r_ras_err <= 1'b1;
            end
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign instr_valid = (r_state == ST_DECIDE);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign ras_err     = r_ras_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model predicts each next fetch
// address, which is queued and compared when the DUT issues the fetch.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         imem_ack = 1'b0;
    logic         stall = 1'b0;
    logic         branch_taken = 1'b0;
    logic         jump = 1'b0;
    logic         call = 1'b0;
    logic         ret = 1'b0;
    logic [W-1:0] sign_imm = '0;
    logic [W-1:0] jump_target = '0;
    logic         imem_req;
    logic         instr_valid;
    logic         ras_err;
    logic [W-1:0] imem_addr;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus1;
    logic [W-1:0] pc_branch;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .sign_imm     (sign_imm),
        .jump         (jump),
        .call         (call),
        .ret          (ret),
        .jump_target  (jump_target),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .pc_branch    (pc_branch),
        .ras_err      (ras_err)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_ras[$];
    logic [W-1:0] m_pc;
    logic         m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Async reset: outputs must take reset values without any clock edge
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_req", 32'(imem_req), 32'd1);
        check_eq("rst_addr", 32'(imem_addr), 32'h0000);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_err", 32'(ras_err), 32'd0);
        m_pc  = 16'h0000;
        m_err = 1'b0;
        m_ras = {};
        exp_q = {};
        exp_q.push_back(m_pc);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // FETCH phase; redirect inputs are waved around while waiting and must be ignored
    task automatic fetch(input int ack_delay);
        logic [W-1:0] e;
        check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : m_pc;
        check_eq("fetch_req", 32'(imem_req), 32'd1);
        check_eq("fetch_addr", 32'(imem_addr), 32'(e));
        check_eq("fetch_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < ack_delay; i++) begin
            jump         = 1'b1;
            branch_taken = 1'b1;
            jump_target  = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq("addr_stable", 32'(imem_addr), 32'(e));
            check_eq("req_held", 32'(imem_req), 32'd1);
        end
        jump         = 1'b0;
        branch_taken = 1'b0;
        imem_ack     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("dec_valid", 32'(instr_valid), 32'd1);
        check_eq("dec_req", 32'(imem_req), 32'd0);
    endtask

    // DECIDE phase with optional stall cycles, then model update and scoreboard push
    task automatic decide(input logic r, input logic c, input logic j, input logic b,
                          input logic [W-1:0] imm, input logic [W-1:0] tgt, input int stalls);
        check_eq("err_state", 32'(ras_err), 32'(m_err));
        check_eq("pc_plus1", 32'(pc_plus1), 32'(W'(m_pc + 16'd1)));
        for (int i = 0; i < stalls; i++) begin
            stall        = 1'b1;
            branch_taken = i[0];
            jump         = 1'b1;
            jump_target  = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
            check_eq("stall_pc", 32'(pc), 32'(m_pc));
        end
        stall        = 1'b0;
        ret          = r;
        call         = c;
        jump         = j;
        branch_taken = b;
        sign_imm     = imm;
        jump_target  = tgt;
        #1;
        check_eq("pc_branch", 32'(pc_branch), 32'(W'(m_pc + 16'd1 + imm)));
        if (r) begin
            if (m_ras.size() != 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = W'(m_pc + 16'd1);
                m_err = 1'b1;
            end
        end else if (c) begin
            if (m_ras.size() == 4) begin
                void'(m_ras.pop_front());
                m_err = 1'b1;
            end
            m_ras.push_back(W'(m_pc + 16'd1));
            m_pc = tgt;
        end else if (j) begin
            m_pc = tgt;
        end else if (b) begin
            m_pc = W'(m_pc + 16'd1 + imm);
        end else begin
            m_pc = W'(m_pc + 16'd1);
        end
        exp_q.push_back(m_pc);
        @(posedge clk);
        @(negedge clk);
        {ret, call, jump, branch_taken} = 4'b0000;
    endtask

    task automatic step(input logic r, input logic c, input logic j, input logic b,
                        input logic [W-1:0] imm, input logic [W-1:0] tgt,
                        input int stalls, input int ack_delay);
        fetch(ack_delay);
        decide(r, c, j, b, imm, tgt, stalls);
    endtask

    initial begin
        apply_reset();
        // Sequential fetch from reset
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, '0, 0, 0);
        // Relative branches backward and forward
        step(0, 0, 1, 0, '0, 16'h0010, 0, 1);
        step(0, 0, 0, 1, 16'hFFFB, '0, 0, 0);
        step(0, 0, 1, 0, '0, 16'h0010, 0, 0);
        step(0, 0, 0, 1, 16'h0005, '0, 0, 2);
        // PC wrap, call/ret, jump beats branch
        step(0, 0, 1, 0, '0, 16'hFFFF, 0, 0);
        step(0, 0, 0, 0, '0, '0, 0, 0);
        step(0, 0, 1, 0, '0, 16'h0020, 0, 0);
        step(0, 1, 0, 0, '0, 16'h0100, 0, 0);
        step(1, 0, 0, 0, '0, '0, 0, 0);
        step(0, 0, 1, 1, 16'h0005, 16'h0ABC, 0, 0);
        // Five nested calls overflow, five rets underflow
        step(0, 0, 1, 0, '0, 16'h0040, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, '0, W'(i * 256), 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, '0, '0, 0, 0);
        // Stalled DECIDE with toggling branch, taken on release
        step(0, 0, 0, 1, 16'h0010, '0, 3, 0);
        step(0, 0, 0, 0, '0, '0, 0, 0);
        // Ack withheld then reset mid-fetch
        check_eq("pre_rst_addr", 32'(imem_addr), 32'(exp_q[0]));
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("wait_req", 32'(imem_req), 32'd1);
        end
        apply_reset();
        // RAS must be empty after reset: ret underflows to pc+1
        step(1, 0, 0, 0, '0, '0, 0, 0);
        step(0, 0, 0, 0, '0, '0, 0, 0);
        fetch(0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
